// File: rtl/mimo_pkg.sv
// Shared definitions for the 2x2 MIMO detector sequencer: default component
// width, controller states, operand packing slots and result entry layout.
package mimo_pkg;

    localparam int W = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_Y = 2'd1,
        HOLD   = 2'd2
    } state_e;

    // Component slot k of a packed operand vector occupies [k*W +: W];
    // the first-listed component sits in the most significant slot.
    localparam int H11_RE = 7;
    localparam int H11_IM = 6;
    localparam int H12_RE = 5;
    localparam int H12_IM = 4;
    localparam int H21_RE = 3;
    localparam int H21_IM = 2;
    localparam int H22_RE = 1;
    localparam int H22_IM = 0;
    localparam int H_SLOTS = 8;

    localparam int Y1_RE = 3;
    localparam int Y1_IM = 2;
    localparam int Y2_RE = 1;
    localparam int Y2_IM = 0;
    localparam int Y_SLOTS = 4;

    localparam int DEMOD_W = 3;
    localparam int IDX_W   = 16;
    localparam int ENTRY_W = 2 * DEMOD_W + IDX_W + 1;

    typedef struct packed {
        logic [DEMOD_W-1:0] d1;
        logic [DEMOD_W-1:0] d2;
        logic [IDX_W-1:0]   idx;
        logic               last;
    } entry_t;

endpackage

// File: rtl/mimo_result_fifo.sv
// Small result queue between the detector sequencer and its consumer.
// The head entry is read straight out of the storage registers.
module mimo_result_fifo
    import mimo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             not_empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_o      = mem_q[rd_q];
    assign not_empty_o = (cnt_q != '0);
    assign count_o     = cnt_q;

endmodule

// File: rtl/mimo_detect_sched.sv
// Sequencer for the combinational 2x2 QR MIMO detector: latches one channel
// matrix per frame, feeds received vectors one at a time, waits a fixed
// settle window, then queues the demodulated symbols with index/last tags.
module mimo_detect_sched #(
    parameter int W      = mimo_pkg::W,
    parameter int SETTLE = 4,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           h_valid,
    output logic           h_ready,
    input  logic [8*W-1:0] h_vec,
    input  logic [15:0]    frame_len,
    input  logic           y_valid,
    output logic           y_ready,
    input  logic [4*W-1:0] y_vec,
    output logic [8*W-1:0] det_h,
    output logic [4*W-1:0] det_y,
    input  logic [2:0]     det_demod_1,
    input  logic [2:0]     det_demod_2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [5:0]     out_demod,
    output logic [15:0]    out_idx,
    output logic           out_last,
    output logic           busy,
    output logic           frame_done
);

    import mimo_pkg::*;

    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    state_e              state_q, state_d;
    logic [8*W-1:0]      det_h_q, det_h_d;
    logic [4*W-1:0]      det_y_q, det_y_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         idx_q, idx_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                frame_done_q, frame_done_d;

    logic                push;
    logic                is_last;
    entry_t              push_entry;
    entry_t              head;
    logic                fifo_ne;
    logic [FCNT_W-1:0]   fifo_count;

    assign is_last    = (idx_q == len_q - 16'd1);
    assign push_entry = {det_demod_1, det_demod_2, idx_q, is_last};

    // Space is reserved at acceptance: the queue can only drain during HOLD.
    assign y_ready = (state_q == WAIT_Y) && (fifo_count < FCNT_W'(DEPTH));
    assign h_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);

    // Next-state logic: frame setup, vector acceptance and settle countdown.
    always_comb begin
        state_d      = state_q;
        det_h_d      = det_h_q;
        det_y_d      = det_y_q;
        len_d        = len_q;
        idx_d        = idx_q;
        scnt_d       = scnt_q;
        frame_done_d = 1'b0;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (h_valid) begin
                    det_h_d = h_vec;
                    len_d   = (frame_len == '0) ? 16'd1 : frame_len;
                    idx_d   = '0;
                    state_d = WAIT_Y;
                end
            end
            WAIT_Y: begin
                if (y_valid && y_ready) begin
                    det_y_d = y_vec;
                    scnt_d  = SCNT_W'(SETTLE - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (scnt_q == '0) begin
                    push = 1'b1;
                    if (is_last) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = WAIT_Y;
                    end
                end else begin
                    scnt_d = scnt_q - SCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and frame-tracking registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            det_h_q      <= '0;
            det_y_q      <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            scnt_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            det_h_q      <= det_h_d;
            det_y_q      <= det_y_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            scnt_q       <= scnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    mimo_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (out_ready),
        .head_o      (head),
        .not_empty_o (fifo_ne),
        .count_o     (fifo_count)
    );

    assign det_h      = det_h_q;
    assign det_y      = det_y_q;
    assign frame_done = frame_done_q;
    assign out_valid  = fifo_ne;
    assign out_demod  = {head.d1, head.d2};
    assign out_idx    = head.idx;
    assign out_last   = head.last;

endmodule

// File: tb/tb_mimo_detect_sched.sv
// Scoreboard bench for mimo_detect_sched with a settle-sensitive detector model.
module tb_mimo_detect_sched;

    localparam int W      = 28;
    localparam int SETTLE = 4;
    localparam int DEPTH  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           h_valid, h_ready;
    logic [8*W-1:0] h_vec;
    logic [15:0]    frame_len;
    logic           y_valid, y_ready;
    logic [4*W-1:0] y_vec;
    logic [8*W-1:0] det_h;
    logic [4*W-1:0] det_y;
    logic [2:0]     det_demod_1, det_demod_2;
    logic           out_valid, out_ready;
    logic [5:0]     out_demod;
    logic [15:0]    out_idx;
    logic           out_last, busy, frame_done;

    always #5 clk = ~clk;

    mimo_detect_sched #(.W(W), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .h_valid(h_valid), .h_ready(h_ready), .h_vec(h_vec), .frame_len(frame_len),
        .y_valid(y_valid), .y_ready(y_ready), .y_vec(y_vec),
        .det_h(det_h), .det_y(det_y),
        .det_demod_1(det_demod_1), .det_demod_2(det_demod_2),
        .out_valid(out_valid), .out_ready(out_ready), .out_demod(out_demod),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    int nchk = 0;
    int npass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Symbol decision of the detector from its operands (low bits mixed).
    function automatic logic [5:0] demod_of(input logic [4*W-1:0] y, input logic [8*W-1:0] h);
        logic [W-1:0] y1re, y1im, y2re, y2im, h11re, h22re;
        y1re  = y[4*W-1 -: W];
        y1im  = y[3*W-1 -: W];
        y2re  = y[2*W-1 -: W];
        y2im  = y[W-1:0];
        h11re = h[8*W-1 -: W];
        h22re = h[2*W-1 -: W];
        return {y1re[2:0] ^ y1im[2:0] ^ h11re[2:0], y2re[2:0] ^ y2im[2:0] ^ h22re[2:0]};
    endfunction

    // Multicycle detector: answer is only correct once operands were stable SETTLE cycles.
    int stab = 0;
    logic [8*W-1:0] prev_h = '0;
    logic [4*W-1:0] prev_y = '0;
    logic [5:0] good;
    assign good        = demod_of(det_y, det_h);
    assign det_demod_1 = (stab >= SETTLE) ? good[5:3] : ~good[5:3];
    assign det_demod_2 = (stab >= SETTLE) ? good[2:0] : ~good[2:0];

    initial forever begin
        @(negedge clk);
        if (det_y !== prev_y || det_h !== prev_h) stab = 1;
        else if (stab < 1000) stab++;
        prev_y = det_y;
        prev_h = det_h;
    end

    // Stimulus driver: operands randomised every cycle, consumer ready by mode.
    int or_mode = 1;
    bit rand_h = 1;
    logic [8*W-1:0] fixed_h = '0;

    initial begin
        y_vec = '0;
        h_vec = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) y_vec[i*W +: W] = W'($urandom);
            if (rand_h) for (int i = 0; i < 8; i++) h_vec[i*W +: W] = W'($urandom);
            else h_vec = fixed_h;
            out_ready = (or_mode == 2) ? 1'($urandom % 2) : (or_mode == 1);
        end
    end

    // Reference model and scoreboard.
    typedef struct {
        logic [22:0] ent;
        int          pcyc;
    } exp_t;
    exp_t sbq[$];
    int   fdq[$];
    exp_t e;
    logic [8*W-1:0] ref_h = '0;
    logic [4*W-1:0] ref_y = '0;
    int ref_len = 1, ref_idx = 0;
    int h_acc = 0, y_acc = 0, fd_seen = 0;
    bit prev_valid = 0, prev_pop = 0;
    int head_start = 0, last_pop = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            sbq.delete();
            fdq.delete();
            ref_h = '0;
            ref_y = '0;
            prev_valid = 0;
            prev_pop = 0;
            last_pop = 0;
        end else begin
            chk("det_h", det_h, ref_h);
            chk("det_y", det_y, ref_y);
            if (out_valid && (!prev_valid || prev_pop)) head_start = cyc;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("out_demod", out_demod, e.ent[22:17]);
                    chk("out_idx", out_idx, e.ent[16:1]);
                    chk("out_last", out_last, e.ent[0]);
                    chk("out_time", head_start, (e.pcyc > last_pop + 1) ? e.pcyc : last_pop + 1);
                end
                last_pop = cyc;
            end
            prev_valid = out_valid;
            prev_pop = out_valid && out_ready;
            if (frame_done) begin
                fd_seen++;
                if (fdq.size() == 0) chk("unexpected_frame_done", 1, 0);
                else chk("frame_done_cyc", cyc, fdq.pop_front());
                chk("h_ready_at_done", h_ready, 1);
            end
            if (h_valid && h_ready) begin
                ref_h = h_vec;
                ref_len = (frame_len == 0) ? 1 : int'(frame_len);
                ref_idx = 0;
                h_acc++;
            end
            if (y_valid && y_ready) begin
                e.ent = {demod_of(y_vec, ref_h), 16'(ref_idx), ref_idx == ref_len - 1};
                e.pcyc = cyc + SETTLE + 1;
                sbq.push_back(e);
                if (ref_idx == ref_len - 1) fdq.push_back(cyc + SETTLE + 1);
                ref_y = y_vec;
                ref_idx++;
                y_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic h_hs(input int flen);
        int h0, t;
        h0 = h_acc;
        t = 0;
        frame_len = 16'(flen);
        h_valid = 1'b1;
        while (h_acc == h0 && t < 200) begin step(); t++; end
        h_valid = 1'b0;
        if (h_acc == h0) chk("h_accept_timeout", 0, 1);
    endtask

    task automatic run_frame(input int flen, input int nvec, input bit gaps);
        int y0, t;
        h_hs(flen);
        y0 = y_acc;
        t = 0;
        while (y_acc - y0 < nvec && t < 2000) begin
            y_valid = gaps ? ($urandom % 3 != 0) : 1'b1;
            step();
            t++;
        end
        y_valid = 1'b0;
        chk("y_accept_count", y_acc - y0, nvec);
        t = 0;
        while ((busy || out_valid) && t < 2000) begin step(); t++; end
        chk("idle_after_frame", {busy, out_valid}, 2'b00);
    endtask

    initial begin
        int y0, fd0, t;
        rst = 1'b0;
        h_valid = 1'b0;
        y_valid = 1'b0;
        frame_len = '0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_h_ready", h_ready, 1);
        chk("rst_y_ready", y_ready, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_demod", out_demod, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_det_h", det_h, 0);
        chk("rst_det_y", det_y, 0);
        rst = 1'b1;
        step();
        chk("h_ready_after_release", h_ready, 1);

        // Basic frame with identity channel, back-to-back vectors.
        fixed_h = '0;
        fixed_h[8*W-1 -: W] = W'(256);
        fixed_h[2*W-1 -: W] = W'(256);
        rand_h = 0;
        or_mode = 1;
        fd0 = fd_seen;
        run_frame(3, 3, 0);
        chk("basic_frame_done_count", fd_seen - fd0, 1);
        rand_h = 1;

        // Zero frame length behaves as one vector.
        fd0 = fd_seen;
        run_frame(0, 1, 0);
        chk("zero_len_frame_done", fd_seen - fd0, 1);
        chk("zero_len_h_ready", h_ready, 1);

        // Backpressure: queue fills, one pop admits exactly one more vector.
        or_mode = 0;
        h_hs(8);
        y0 = y_acc;
        y_valid = 1'b1;
        repeat (60) step();
        chk("bp_accepted_4", y_acc - y0, 4);
        chk("bp_y_ready_low", y_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        or_mode = 1;
        step();
        or_mode = 0;
        repeat (40) step();
        chk("bp_accepted_5", y_acc - y0, 5);
        chk("bp_y_ready_low2", y_ready, 0);
        or_mode = 1;
        t = 0;
        while (y_acc - y0 < 8 && t < 500) begin step(); t++; end
        y_valid = 1'b0;
        chk("bp_accepted_8", y_acc - y0, 8);
        t = 0;
        while ((busy || out_valid) && t < 500) begin step(); t++; end
        chk("bp_idle", {busy, out_valid}, 2'b00);

        // Random frames with random gaps and random consumer stalls.
        or_mode = 2;
        for (int k = 0; k < 8; k++) begin
            int len;
            len = $urandom_range(1, 7);
            run_frame(len, len, 1);
        end

        // Reset while a vector is settling and two results are queued.
        or_mode = 0;
        h_hs(8);
        y0 = y_acc;
        y_valid = 1'b1;
        t = 0;
        while (y_acc - y0 < 3 && t < 200) begin step(); t++; end
        y_valid = 1'b0;
        step();
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_h_ready", h_ready, 1);
        chk("mid_rst_y_ready", y_ready, 0);
        step();
        step();
        rst = 1'b1;
        or_mode = 1;
        repeat (30) step();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);

        // One more frame after the reset to confirm clean restart.
        run_frame(2, 2, 0);

        repeat (10) step();
        chk("scoreboard_empty", sbq.size(), 0);
        chk("frame_done_queue_empty", fdq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1);
    end

endmodule
